// File: rtl/toy_dispatch_xbar_rr.sv
// Slot-to-execution-unit dispatch crossbar with one round-robin arbiter and one
// output register per EU. Slots target the lowest set bit of their EU select.
module toy_dispatch_xbar_rr #(
  parameter int SLOT_NUM = 4,
  parameter int EU_NUM   = 4,
  parameter int PLD_W    = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [SLOT_NUM-1:0]       v_slot_vld,
  input  logic [SLOT_NUM*EU_NUM-1:0] v_slot_eu_sel,
  input  logic [SLOT_NUM*PLD_W-1:0] v_slot_pld,
  output logic [SLOT_NUM-1:0]       v_slot_rdy,
  output logic [EU_NUM-1:0]         v_eu_vld,
  output logic [EU_NUM*PLD_W-1:0]   v_eu_pld,
  input  logic [EU_NUM-1:0]         v_eu_rdy
);

  localparam int PW = $clog2(SLOT_NUM);

  logic [SLOT_NUM-1:0][EU_NUM-1:0] req_oh;
  logic [EU_NUM-1:0]               win_vld;
  logic [EU_NUM-1:0][PW-1:0]       win_idx;
  logic [EU_NUM-1:0]               load;
  int unsigned                     scan_idx;

  logic [EU_NUM-1:0]               full_q, full_d;
  logic [EU_NUM-1:0][PLD_W-1:0]    pld_q, pld_d;
  logic [EU_NUM-1:0][PW-1:0]       ptr_q, ptr_d;

  // sel & -sel isolates the lowest set bit, so an all-zero select requests nothing
  always_comb begin
    for (int unsigned i = 0; i < SLOT_NUM; i++) begin
      logic [EU_NUM-1:0] sel;
      sel = v_slot_eu_sel[i*EU_NUM +: EU_NUM];
      req_oh[i] = v_slot_vld[i] ? (sel & (~sel + 1'b1)) : '0;
    end
  end

  always_comb begin
    win_vld  = '0;
    win_idx  = '0;
    scan_idx = 0;
    for (int unsigned e = 0; e < EU_NUM; e++) begin
      for (int unsigned off = 0; off < SLOT_NUM; off++) begin
        scan_idx = int'(ptr_q[e]) + off;
        if (scan_idx >= SLOT_NUM) scan_idx = scan_idx - SLOT_NUM;
        if (!win_vld[e] && req_oh[scan_idx][e]) begin
          win_vld[e] = 1'b1;
          win_idx[e] = PW'(scan_idx);
        end
      end
    end
  end

  // An EU may take a new payload when empty or being drained this same cycle
  always_comb begin
    for (int unsigned e = 0; e < EU_NUM; e++) begin
      load[e] = win_vld[e] && (!full_q[e] || v_eu_rdy[e]) && !flush && !rst;
    end
  end

  always_comb begin
    v_slot_rdy = '0;
    for (int unsigned e = 0; e < EU_NUM; e++) begin
      if (load[e]) v_slot_rdy[win_idx[e]] = 1'b1;
    end
  end

  always_comb begin
    full_d = full_q;
    pld_d  = pld_q;
    ptr_d  = ptr_q;
    for (int unsigned e = 0; e < EU_NUM; e++) begin
      if (flush) begin
        full_d[e] = 1'b0;
        pld_d[e]  = '0;
      end else if (load[e]) begin
        full_d[e] = 1'b1;
        pld_d[e]  = v_slot_pld[win_idx[e]*PLD_W +: PLD_W];
        ptr_d[e]  = (win_idx[e] == PW'(SLOT_NUM-1)) ? '0 : win_idx[e] + 1'b1;
      end else if (full_q[e] && v_eu_rdy[e]) begin
        full_d[e] = 1'b0;
        pld_d[e]  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= '0;
      pld_q  <= '0;
      ptr_q  <= '0;
    end else begin
      full_q <= full_d;
      pld_q  <= pld_d;
      ptr_q  <= ptr_d;
    end
  end

  assign v_eu_vld = full_q;
  assign v_eu_pld = pld_q;

endmodule

// File: tb/tb_toy_dispatch_xbar_rr.sv
// Randomized and directed checks of toy_dispatch_xbar_rr against a
// distance-from-pointer reference model of per-EU round-robin dispatch.
module tb_toy_dispatch_xbar_rr;

  localparam int SLOT = 4;
  localparam int EU   = 4;
  localparam int PW   = 64;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic [SLOT-1:0]      v_slot_vld;
  logic [SLOT*EU-1:0]   v_slot_eu_sel;
  logic [SLOT*PW-1:0]   v_slot_pld;
  logic [SLOT-1:0]      v_slot_rdy;
  logic [EU-1:0]        v_eu_vld;
  logic [EU*PW-1:0]     v_eu_pld;
  logic [EU-1:0]        v_eu_rdy;

  int checks   = 0;
  int failures = 0;

  bit          m_full [EU];
  logic [63:0] m_pld  [EU];
  int          m_ptr  [EU];
  logic [SLOT-1:0] last_rdy;

  toy_dispatch_xbar_rr #(.SLOT_NUM(SLOT), .EU_NUM(EU), .PLD_W(PW)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .v_slot_vld    (v_slot_vld),
    .v_slot_eu_sel (v_slot_eu_sel),
    .v_slot_pld    (v_slot_pld),
    .v_slot_rdy    (v_slot_rdy),
    .v_eu_vld      (v_eu_vld),
    .v_eu_pld      (v_eu_pld),
    .v_eu_rdy      (v_eu_rdy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int e = 0; e < EU; e++) begin
      m_full[e] = 1'b0;
      m_pld[e]  = '0;
      m_ptr[e]  = 0;
    end
  endtask

  // Target EU of a slot: index of lowest set select bit, -1 if none or invalid
  function automatic int target(input int i);
    logic [EU-1:0] s;
    s = v_slot_eu_sel[i*EU +: EU];
    if (!v_slot_vld[i] || s == '0) return -1;
    for (int b = 0; b < EU; b++) if (s[b]) return b;
    return -1;
  endfunction

  // Called just after a negedge with inputs applied; returns at the next negedge
  task automatic run_cycle();
    int win [EU];
    int best, d;
    logic [SLOT-1:0] exp_rdy;
    exp_rdy = '0;
    for (int e = 0; e < EU; e++) begin
      win[e] = -1;
      best = SLOT;
      for (int i = 0; i < SLOT; i++) begin
        if (target(i) == e) begin
          d = (i - m_ptr[e] + SLOT) % SLOT;
          if (d < best) begin
            best = d;
            win[e] = i;
          end
        end
      end
      if (win[e] >= 0 && (!m_full[e] || v_eu_rdy[e]) && !flush)
        exp_rdy[win[e]] = 1'b1;
      else
        win[e] = -1;
    end
    #1;
    last_rdy = v_slot_rdy;
    check("rdy", 64'(last_rdy), 64'(exp_rdy));
    @(posedge clk);
    for (int e = 0; e < EU; e++) begin
      if (flush) begin
        m_full[e] = 1'b0;
        m_pld[e]  = '0;
      end else if (win[e] >= 0) begin
        m_full[e] = 1'b1;
        m_pld[e]  = v_slot_pld[win[e]*PW +: PW];
        m_ptr[e]  = (win[e] + 1) % SLOT;
      end else if (m_full[e] && v_eu_rdy[e]) begin
        m_full[e] = 1'b0;
        m_pld[e]  = '0;
      end
    end
    #1;
    for (int e = 0; e < EU; e++) begin
      check("eu_vld", 64'(v_eu_vld[e]), 64'(m_full[e]));
      check("eu_pld", v_eu_pld[e*PW +: PW], m_pld[e]);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    flush = 1'b0;
    v_slot_vld = '0;
    v_slot_eu_sel = '0;
    v_slot_pld = '0;
    v_eu_rdy = '0;
  endtask

  task automatic set_slot(input int i, input logic [EU-1:0] sel, input logic [63:0] pld);
    v_slot_vld[i] = 1'b1;
    v_slot_eu_sel[i*EU +: EU] = sel;
    v_slot_pld[i*PW +: PW] = pld;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    for (int i = 0; i < SLOT; i++) set_slot(i, 4'b0001 << i, 64'h100 + 64'(i));
    v_eu_rdy = '1;
    #3;
    check("rst_rdy", 64'(v_slot_rdy), 64'h0);
    check("rst_vld", 64'(v_eu_vld), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();

    // Single dispatch to EU2
    set_slot(2, 4'b0100, 64'hA5);
    run_cycle();
    check("single_rdy", 64'(last_rdy), 64'h4);
    check("single_vld", 64'(v_eu_vld), 64'h4);
    check("single_pld", v_eu_pld[2*PW +: PW], 64'hA5);
    idle_inputs();
    v_eu_rdy = '1;
    run_cycle();

    // Round-robin on EU1 with continuous drain
    idle_inputs();
    v_eu_rdy = 4'b0010;
    for (int i = 0; i < SLOT; i++) set_slot(i, 4'b0010, 64'h1000 + 64'(i));
    for (int k = 0; k < 5; k++) begin
      logic [SLOT-1:0] exp1;
      exp1 = 4'b0001 << (k % SLOT);
      run_cycle();
      check("rr_order", 64'(last_rdy), 64'(exp1));
    end

    // Backpressure on EU0
    idle_inputs();
    v_eu_rdy = '1;
    run_cycle();
    idle_inputs();
    set_slot(0, 4'b0001, 64'hB0B0);
    run_cycle();
    idle_inputs();
    set_slot(1, 4'b0101, 64'hC1C1);
    for (int k = 0; k < 3; k++) begin
      run_cycle();
      check("bp_rdy", 64'(last_rdy[1]), 64'h0);
      check("bp_pld", v_eu_pld[0 +: PW], 64'hB0B0);
    end
    v_eu_rdy = 4'b0001;
    run_cycle();
    check("bp_release", 64'(last_rdy[1]), 64'h1);
    check("bp_newpld", v_eu_pld[0 +: PW], 64'hC1C1);

    // Parallel loads plus an all-zero select
    idle_inputs();
    v_eu_rdy = '1;
    run_cycle();
    idle_inputs();
    set_slot(0, 4'b0001, 64'h11);
    set_slot(1, 4'b1000, 64'h22);
    set_slot(2, 4'b0000, 64'h33);
    run_cycle();
    check("par_rdy", 64'(last_rdy), 64'h3);
    check("par_vld", 64'(v_eu_vld), 64'h9);

    // Flush with two EUs full and slot 0 requesting
    idle_inputs();
    flush = 1'b1;
    set_slot(0, 4'b0001, 64'h77);
    run_cycle();
    check("flush_rdy", 64'(last_rdy), 64'h0);
    check("flush_vld", 64'(v_eu_vld), 64'h0);
    flush = 1'b0;
    run_cycle();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      flush = ($urandom_range(15) == 0);
      v_eu_rdy = 4'($urandom);
      for (int i = 0; i < SLOT; i++) begin
        v_slot_vld[i] = ($urandom_range(3) != 0);
        v_slot_eu_sel[i*EU +: EU] = ($urandom_range(7) == 0) ? 4'b0000 : 4'($urandom);
        v_slot_pld[i*PW +: PW] = {$urandom, $urandom};
      end
      run_cycle();
    end

    // Mid-operation reset with a non-zero EU0 pointer
    idle_inputs();
    flush = 1'b1;
    run_cycle();
    idle_inputs();
    set_slot(1, 4'b0001, 64'hD1);
    set_slot(2, 4'b0010, 64'hD2);
    run_cycle();
    #2;
    rst = 1'b1;
    #1;
    check("mrst_vld", 64'(v_eu_vld), 64'h0);
    check("mrst_rdy", 64'(v_slot_rdy), 64'h0);
    check("mrst_pld", 64'(|v_eu_pld), 64'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    for (int i = 1; i < SLOT; i++) set_slot(i, 4'b0001, 64'hE0 + 64'(i));
    run_cycle();
    check("mrst_first", 64'(last_rdy), 64'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
